// File: rtl/mesi_snoop_if.sv
`default_nettype none
// ============================================================================
// Module   : mesi_snoop_if
// Purpose  : Coherence-bus, tag/state/data array and local-update signals of
//            the MESI snoop controller.
// Revision : 1.0
// ============================================================================
interface mesi_snoop_if #(
    parameter int N_SETS     = 32,
    parameter int ASSOC      = 1,
    parameter int BLOCK_SIZE = 2
);
    localparam int SET_W    = $clog2(N_SETS);
    localparam int WAY_W    = (ASSOC > 1) ? $clog2(ASSOC) : 1;
    localparam int WORD_W   = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int TAG_BITS = 32 - SET_W - $clog2(BLOCK_SIZE) - 2;

    logic                      snoop_req;
    logic [31:0]               snoop_addr;
    logic [1:0]                snoop_type;
    logic                      snoop_ack;
    logic                      snoop_hit;
    logic                      snoop_dirty;

    logic                      flush_valid;
    logic                      flush_last;
    logic [31:0]               flush_data;
    logic                      flush_ready;

    logic [SET_W-1:0]          set_sel;
    logic [WAY_W-1:0]          way_sel;
    logic [WORD_W-1:0]         word_sel;
    logic [ASSOC*TAG_BITS-1:0] tag_in;
    logic [ASSOC*2-1:0]        state_in;
    logic [31:0]               data_in;

    logic                      st_wr;
    logic [SET_W-1:0]          st_set;
    logic [WAY_W-1:0]          st_way;
    logic [1:0]                st_new;

    logic                      local_upd_req;
    logic [SET_W-1:0]          local_set;
    logic [WAY_W-1:0]          local_way;
    logic [1:0]                local_state;
    logic                      local_upd_ack;

    logic                      busy;

    // Controller view
    modport slave (
        input  snoop_req, snoop_addr, snoop_type,
        output snoop_ack, snoop_hit, snoop_dirty,
        output flush_valid, flush_last, flush_data,
        input  flush_ready,
        output set_sel, way_sel, word_sel,
        input  tag_in, state_in, data_in,
        output st_wr, st_set, st_way, st_new,
        input  local_upd_req, local_set, local_way, local_state,
        output local_upd_ack, busy
    );

    // Bus / cache-array / cache-controller view
    modport master (
        output snoop_req, snoop_addr, snoop_type,
        input  snoop_ack, snoop_hit, snoop_dirty,
        input  flush_valid, flush_last, flush_data,
        output flush_ready,
        input  set_sel, way_sel, word_sel,
        output tag_in, state_in, data_in,
        input  st_wr, st_set, st_way, st_new,
        output local_upd_req, local_set, local_way, local_state,
        input  local_upd_ack, busy
    );
endinterface
`default_nettype wire

// File: rtl/mesi_snoop_controller.sv
`default_nettype none
// ============================================================================
// Module   : mesi_snoop_controller
// Purpose  : Snoop responder and MESI state-update sequencer for an N-way,
//            multi-word-block L1; snoops take priority over local updates.
// Revision : 1.0
// ============================================================================
module mesi_snoop_controller #(
    parameter int N_SETS     = 32,
    parameter int ASSOC      = 1,
    parameter int BLOCK_SIZE = 2
) (
    input  wire          clk,
    input  wire          rst,
    mesi_snoop_if.slave  bus
);
    localparam int SET_W    = $clog2(N_SETS);
    localparam int WAY_W    = (ASSOC > 1) ? $clog2(ASSOC) : 1;
    localparam int WORD_W   = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int OFF_W    = $clog2(BLOCK_SIZE);
    localparam int TAG_BITS = 32 - SET_W - OFF_W - 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOOKUP = 3'd1;
    localparam logic [2:0] ST_FLUSH  = 3'd2;
    localparam logic [2:0] ST_UPDATE = 3'd3;
    localparam logic [2:0] ST_LOCAL  = 3'd4;

    localparam logic [1:0] MESI_M = 2'd0;
    localparam logic [1:0] MESI_S = 2'd2;
    localparam logic [1:0] MESI_I = 2'd3;

    localparam logic [1:0] BUS_RD   = 2'd0;
    localparam logic [1:0] BUS_RDX  = 2'd1;
    localparam logic [1:0] BUS_NONE = 2'd3;

    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(BLOCK_SIZE - 1);

    logic [2:0]          state;
    logic [SET_W-1:0]    snp_set;
    logic [TAG_BITS-1:0] snp_tag;
    logic [1:0]          snp_type;
    logic                hit;
    logic                dirty;
    logic [WAY_W-1:0]    hit_way;
    logic [WORD_W-1:0]   beat;
    logic [SET_W-1:0]    loc_set;
    logic [WAY_W-1:0]    loc_way;
    logic [1:0]          loc_state;

    logic [ASSOC-1:0]    way_match;
    logic                lk_hit;
    logic                lk_dirty;
    logic [WAY_W-1:0]    lk_way;
    logic [1:0]          lk_state;
    logic                lk_flush;

    // Byte and word offset bits play no part in a block-granular snoop.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.snoop_addr[2+OFF_W-1:0];

    generate
        for (genvar w = 0; w < ASSOC; w++) begin : g_match
            assign way_match[w] = (bus.tag_in[w*TAG_BITS +: TAG_BITS] == snp_tag) &&
                                  (bus.state_in[w*2 +: 2] != MESI_I);
        end
    endgenerate

    // Scan from the top way down so the lowest matching way is the one kept.
    always_comb begin
        lk_hit   = 1'b0;
        lk_way   = '0;
        lk_state = MESI_I;
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (way_match[w]) begin
                lk_hit   = 1'b1;
                lk_way   = WAY_W'(w);
                lk_state = bus.state_in[w*2 +: 2];
            end
        end
        if (snp_type == BUS_NONE) begin
            lk_hit = 1'b0;
        end
        lk_dirty = lk_hit && (lk_state == MESI_M);
        lk_flush = lk_dirty && ((snp_type == BUS_RD) || (snp_type == BUS_RDX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            snp_set   <= '0;
            snp_tag   <= '0;
            snp_type  <= '0;
            hit       <= 1'b0;
            dirty     <= 1'b0;
            hit_way   <= '0;
            beat      <= '0;
            loc_set   <= '0;
            loc_way   <= '0;
            loc_state <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.snoop_req) begin
                        snp_tag  <= bus.snoop_addr[31 -: TAG_BITS];
                        snp_set  <= bus.snoop_addr[2+OFF_W +: SET_W];
                        snp_type <= bus.snoop_type;
                        state    <= ST_LOOKUP;
                    end else if (bus.local_upd_req) begin
                        loc_set   <= bus.local_set;
                        loc_way   <= bus.local_way;
                        loc_state <= bus.local_state;
                        state     <= ST_LOCAL;
                    end
                end
                ST_LOOKUP: begin
                    hit     <= lk_hit;
                    dirty   <= lk_dirty;
                    hit_way <= lk_way;
                    beat    <= '0;
                    state   <= lk_flush ? ST_FLUSH : ST_UPDATE;
                end
                ST_FLUSH: begin
                    if (bus.flush_ready) begin
                        if (beat == LAST_BEAT) begin
                            beat  <= '0;
                            state <= ST_UPDATE;
                        end else begin
                            beat <= beat + WORD_W'(1);
                        end
                    end
                end
                ST_UPDATE: state <= ST_IDLE;
                ST_LOCAL:  state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    logic in_flush;
    logic in_update;
    logic in_local;
    logic snoop_wr;

    assign in_flush  = (state == ST_FLUSH);
    assign in_update = (state == ST_UPDATE);
    assign in_local  = (state == ST_LOCAL);
    assign snoop_wr  = in_update && hit;

    assign bus.set_sel     = snp_set;
    assign bus.way_sel     = hit_way;
    assign bus.word_sel    = beat;

    assign bus.flush_valid = in_flush;
    assign bus.flush_last  = in_flush && (beat == LAST_BEAT);
    assign bus.flush_data  = in_flush ? bus.data_in : 32'd0;

    assign bus.snoop_ack   = in_update;
    assign bus.snoop_hit   = in_update && hit;
    assign bus.snoop_dirty = in_update && dirty;

    // A snoop hit on BusRd drops to S; BusRdX and BusUpgr both invalidate.
    assign bus.st_wr  = snoop_wr || in_local;
    assign bus.st_set = snoop_wr ? snp_set : (in_local ? loc_set : '0);
    assign bus.st_way = snoop_wr ? hit_way : (in_local ? loc_way : '0);
    assign bus.st_new = snoop_wr ? ((snp_type == BUS_RD) ? MESI_S : MESI_I)
                                 : (in_local ? loc_state : 2'd0);

    assign bus.local_upd_ack = in_local;
    assign bus.busy          = (state != ST_IDLE);
endmodule
`default_nettype wire
